// File: rtl/out_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the out_uart_tx output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  // TX state encoding, kept as plain constants for legacy tool flows
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  // Width needed for a baud counter that runs 0..clks_per_bit-1
  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/out_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : out_uart_tx_if
//  Description : Capture bus and serial/status signals of the output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface out_uart_tx_if #(
  parameter int DEPTH = 8
);
  logic [7:0]                   data_in;
  logic                         capture_en;
  logic                         tx;
  logic                         busy;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  logic                         overflow;

  modport master (
    output data_in, capture_en,
    input  tx, busy, fifo_count, overflow
  );

  modport slave (
    input  data_in, capture_en,
    output tx, busy, fifo_count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/out_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock circular FIFO with combinational head read.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic      [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status flags and qualified push/pop; a push into a full FIFO is only
  // legal when the head leaves in the same cycle
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = mem[rd_ptr];
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/out_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : out_uart_tx
//  Description : Samples the CPU result bus, queues selected values and
//                serializes them as 8N1 UART frames. Never backpressures:
//                captures that find the FIFO full are dropped and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 8,
  parameter int CHANGE_ONLY  = 1
) (
  input wire logic    clk,
  input wire logic    reset,
  out_uart_tx_if.slave bus
);

  localparam int BW = baud_cnt_width(CLKS_PER_BIT);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  state_t                 state;
  logic [BW-1:0]          baud_cnt;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   tx_bit;
  logic                   primed;
  logic [7:0]             last_val;
  logic                   overflow_flag;

  logic                   capture_req;
  logic                   pop_req;
  logic                   push_ok;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_cnt;
  logic [7:0]             fifo_head;

  // Capture filter, head pop in IDLE, and push acceptance (room or same-cycle pop)
  always_comb begin
    capture_req = bus.capture_en &&
                  ((CHANGE_ONLY == 0) || !primed || (bus.data_in != last_val));
    pop_req     = (state == ST_IDLE) && !fifo_empty;
    push_ok     = capture_req && (!fifo_full || pop_req);
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_ok),
    .push_data (bus.data_in),
    .pop       (pop_req),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Change-detection history and sticky overflow; rejected values leave history alone
  always_ff @(posedge clk) begin
    if (reset) begin
      primed        <= 1'b0;
      last_val      <= 8'h00;
      overflow_flag <= 1'b0;
    end else begin
      if (push_ok) begin
        primed   <= 1'b1;
        last_val <= bus.data_in;
      end
      if (capture_req && !push_ok) begin
        overflow_flag <= 1'b1;
      end
    end
  end

  // TX framing FSM; tx is registered and updated on each state/bit change
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_bit    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_bit   <= 1'b1;
          baud_cnt <= '0;
          if (pop_req) begin
            shift_reg <= fifo_head;
            tx_bit    <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_bit   <= shift_reg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              tx_bit <= 1'b1;
              state  <= ST_STOP;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
              tx_bit    <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.tx         = tx_bit;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.fifo_count = fifo_cnt;
  assign bus.overflow   = overflow_flag;

endmodule
`default_nettype wire

// File: tb/tb_out_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_uart_tx
//  Description : Scoreboard bench for out_uart_tx; one instance per
//                CHANGE_ONLY setting, frames decoded by per-instance monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_out_uart_tx;

  localparam int CPB = 4;
  localparam int DEP = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  out_uart_tx_if #(.DEPTH(DEP)) if0 ();
  out_uart_tx_if #(.DEPTH(DEP)) if1 ();

  out_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEP), .CHANGE_ONLY(0)) dut0 (
    .clk(clk), .reset(rst0), .bus(if0.slave)
  );
  out_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEP), .CHANGE_ONLY(1)) dut1 (
    .clk(clk), .reset(rst1), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_tx(input int id);
    return (id == 0) ? if0.tx : if1.tx;
  endfunction
  function automatic logic get_busy(input int id);
    return (id == 0) ? if0.busy : if1.busy;
  endfunction
  function automatic logic get_rst(input int id);
    return (id == 0) ? rst0 : rst1;
  endfunction

  // Frame monitor: decodes tx, checks shape and pops the scoreboard
  task automatic mon(input int id);
    logic [7:0] got, exp;
    logic shape_ok, aborted, bitv, t;
    int   qs;
    forever begin
      @(posedge clk); #1;
      if (!get_rst(id) && !get_tx(id)) begin
        got = '0; shape_ok = 1'b1; aborted = 1'b0; bitv = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k != 0) begin @(posedge clk); #1; end
          if (get_rst(id)) begin aborted = 1'b1; break; end
          t = get_tx(id);
          if (!get_busy(id)) shape_ok = 1'b0;
          if (k < CPB) begin
            if (t) shape_ok = 1'b0;
          end else if (k >= 9 * CPB) begin
            if (!t) shape_ok = 1'b0;
          end else if (k % CPB == 0) begin
            bitv = t;
            got[(k / CPB) - 1] = t;
          end else if (t != bitv) begin
            shape_ok = 1'b0;
          end
        end
        qs = (id == 0) ? exp_q0.size() : exp_q1.size();
        if (aborted) begin
          if (qs != 0) begin
            if (id == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
          end
        end else begin
          if (qs == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame dut%0d: got %0h expected none", id, got);
          end else begin
            exp = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("frame_data_dut%0d", id), {24'd0, got}, {24'd0, exp});
          end
          chk($sformatf("frame_shape_dut%0d", id), {31'd0, shape_ok}, 32'd1);
          @(posedge clk); #1;
          if (!get_rst(id))
            chk($sformatf("idle_gap_dut%0d", id), {30'd0, get_tx(id), get_busy(id)}, 32'b10);
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic wait_idle(input int id, input string name);
    int n = 0;
    while (get_busy(id) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk(name, 32'd1, 32'd0);
  endtask

  initial begin
    logic ok0, ok1;
    int   n;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.data_in = 8'h00; if0.capture_en = 1'b0;
    if1.data_in = 8'h00; if1.capture_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state_dut0", {if0.tx, if0.busy, 3'(if0.fifo_count), if0.overflow}, {1'b1, 1'b0, 3'd0, 1'b0});
    chk("reset_state_dut1", {if1.tx, if1.busy, 3'(if1.fifo_count), if1.overflow}, {1'b1, 1'b0, 3'd0, 1'b0});
    rst0 = 1'b0; rst1 = 1'b0;

    // 1: quiet idle
    ok0 = 1'b1; ok1 = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!(if0.tx && !if0.busy && if0.fifo_count == 0 && !if0.overflow)) ok0 = 1'b0;
      if (!(if1.tx && !if1.busy && if1.fifo_count == 0 && !if1.overflow)) ok1 = 1'b0;
    end
    chk("idle50_dut0", {31'd0, ok0}, 32'd1);
    chk("idle50_dut1", {31'd0, ok1}, 32'd1);

    // 2: single 0xA5 frame, latency and length
    if1.data_in = 8'hA5; if1.capture_en = 1'b1; exp_q1.push_back(8'hA5);
    @(negedge clk); if1.capture_en = 1'b0;
    chk("lat_push_edge", {if1.tx, if1.busy, 3'(if1.fifo_count)}, {1'b1, 1'b0, 3'd1});
    @(negedge clk);
    chk("lat_pop_edge", {if1.tx, if1.busy, 3'(if1.fifo_count)}, {1'b0, 1'b1, 3'd0});
    n = 0;
    while (if1.busy && n < 200) begin n++; @(negedge clk); end
    chk("busy_cycles", n, FRAME);
    repeat (5) @(negedge clk);

    // 3: change-only, held 0x03 then 0x04
    if1.data_in = 8'h03; if1.capture_en = 1'b1; exp_q1.push_back(8'h03);
    repeat (100) @(negedge clk);
    if1.data_in = 8'h04; exp_q1.push_back(8'h04);
    repeat (100) @(negedge clk);
    if1.capture_en = 1'b0;
    chk("chg_overflow", {31'd0, if1.overflow}, 32'd0);

    // 5: reset in the 15th cycle of a frame discards it and the queue
    if1.data_in = 8'h11; if1.capture_en = 1'b1; exp_q1.push_back(8'h11);
    @(negedge clk); if1.data_in = 8'h22;
    @(negedge clk); if1.capture_en = 1'b0;
    wait_idle(1, "pre_abort_timeout");
    chk("abort_queued", 3'(if1.fifo_count), 32'd1);
    repeat (14) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    chk("abort_state", {if1.tx, if1.busy, 3'(if1.fifo_count)}, {1'b1, 1'b0, 3'd0});
    rst1 = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_discard", {28'd0, 3'(if1.fifo_count), if1.busy}, 32'd0);

    // 6: push+pop while full (CHANGE_ONLY=0)
    for (int i = 0; i < 5; i++) begin
      if0.data_in = 8'h30 + 8'(i); if0.capture_en = 1'b1; exp_q0.push_back(8'h30 + 8'(i));
      @(negedge clk);
    end
    if0.capture_en = 1'b0;
    chk("fill_count", 3'(if0.fifo_count), 32'd4);
    chk("fill_overflow", {31'd0, if0.overflow}, 32'd0);
    wait_idle(0, "full_idle_timeout");
    chk("full_at_idle", 3'(if0.fifo_count), 32'd4);
    if0.data_in = 8'h35; if0.capture_en = 1'b1; exp_q0.push_back(8'h35);
    @(negedge clk); if0.capture_en = 1'b0;
    chk("pushpop_count", 3'(if0.fifo_count), 32'd4);
    chk("pushpop_overflow", {31'd0, if0.overflow}, 32'd0);
    repeat (250) @(negedge clk);

    // 4: burst of 10 with CHANGE_ONLY=0 -> 0..4 sent, rest dropped
    rst0 = 1'b1; @(negedge clk); rst0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if0.data_in = 8'(i); if0.capture_en = 1'b1;
      if (i < 5) exp_q0.push_back(8'(i));
      @(negedge clk);
    end
    if0.capture_en = 1'b0;
    chk("burst_overflow", {31'd0, if0.overflow}, 32'd1);
    chk("burst_count", 3'(if0.fifo_count), 32'd4);
    repeat (5 * (FRAME + 1) + 20) @(negedge clk);
    chk("overflow_sticky", {31'd0, if0.overflow}, 32'd1);
    chk("burst_drained", 3'(if0.fifo_count), 32'd0);

    chk("pending_dut0", exp_q0.size(), 32'd0);
    chk("pending_dut1", exp_q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/out_uart_tx.md
Name: out_uart_tx

Overview:
Downstream output stage for the redux CPU. It samples the CPU's 8-bit `out` bus (the ULA result) every clock and queues selected values in a small FIFO. It serializes them as 8N1 UART frames on a single `tx` pin. This makes program results observable off-chip without stalling the CPU. The CPU never sees backpressure: values that arrive while the FIFO is full are dropped and flagged.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (must be ≥2)
DEPTH, 8, FIFO entries (power of two, ≥2)
CHANGE_ONLY, 1, 1 = capture only when data_in differs from last captured value; 0 = capture every enabled cycle

Ports:
clk  input  1  system clock, shared with redux
reset  input  1  synchronous, active-high
data_in  input  8  redux `out` bus
capture_en  input  1  sampling enable
tx  output  1  UART serial line, idle high
busy  output  1  frame in progress
fifo_count  output  $clog2(DEPTH+1)  queued entries
overflow  output  1  sticky: a capture was dropped

Behaviour:
- Reset is synchronous and active-high; one clock, `clk`. During reset: tx=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, FIFO pointers=0, primed=0, last=0x00.
- Reset mid-frame aborts the frame; tx=1 on the cycle after the reset edge; queued data is discarded.
- Capture request in a cycle: capture_en && (CHANGE_ONLY==0 || !primed || data_in!=last).
- On an accepted capture: write data_in, set last=data_in, set primed=1.
- The first enabled cycle after reset is always captured.
- Push is accepted if fifo_count<DEPTH, or if a pop occurs in the same cycle.
- Otherwise the capture is dropped, overflow is set, and last/primed are not updated. A rejected value is retried next cycle if it still differs.
- overflow clears only on reset.
- FIFO: circular, read/write pointers wrap modulo DEPTH.
- Simultaneous push+pop leaves fifo_count unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1, busy=0. If FIFO is non-empty: pop head into the shift register, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit bit index runs 0..7; after bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- busy=1 in START, DATA and STOP.
- tx is a registered output.
- Latency: a byte pushed at edge E into an empty FIFO while IDLE is popped at E+1; tx falls after E+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles. The return to IDLE costs 1 cycle, so back-to-back frames are separated by 1 idle cycle of tx=1.
- Baud counter counts 0..CLKS_PER_BIT-1, resets on every state/bit change, with no cumulative drift.

Decomposition:
- Shared package `uart_pkg`:
  - state typedef (IDLE/START/DATA/STOP)
  - DATA_BITS=8 constant
  - function for the baud-counter width
- One sub-module, `sync_fifo`:
  - parameterized width/depth
  - push/pop/full/empty/count ports
  - the same reset semantics as this block
- The TX FSM, change detection and overflow logic stay in the top.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and DEPTH=4 unless noted.
1. Assert reset for 3 cycles, then release with capture_en=0 → tx=1, busy=0, fifo_count=0, overflow=0 for 50 cycles.
2. CHANGE_ONLY=1; data_in=0xA5 with capture_en=1 for 1 cycle → tx: 4 cycles of 0, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles of 1. Total 40 busy cycles; tx falls 1 cycle after the push edge.
3. CHANGE_ONLY=1; hold data_in=0x03 for 100 cycles → exactly one frame; changing to 0x04 → exactly one more frame.
4. CHANGE_ONLY=0; capture_en=1 for 10 cycles with incrementing data 0x00..0x09:
   - 0x00 is popped, then 0x01..0x04 fill the FIFO.
   - 0x05..0x09 are dropped, overflow=1.
   - Serialized output is 0x00..0x04.
5. Reset asserted at the 15th cycle of a frame → tx=1 and fifo_count=0 on the next cycle; no further frames.
6. Push and pop in the same cycle with fifo_count=4 (DEPTH=4) → push accepted, fifo_count stays 4, overflow stays 0.
